// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// The ALU result is captured into a one-entry response slot tagged with its owner.
module alu_arbiter #(
    parameter int W    = 64,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_opcode,
    input  logic [W-1:0]    req0_a,
    input  logic [W-1:0]    req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_opcode,
    input  logic [W-1:0]    req1_a,
    input  logic [W-1:0]    req1_b,
    output logic [3:0]      alu_opcode,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    input  logic [W-1:0]    alu_result,
    input  logic            alu_cout,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [W-1:0]    rsp_result,
    output logic            rsp_cout,
    output logic [CNTW-1:0] cnt0,
    output logic [CNTW-1:0] cnt1
);

    logic            out_valid_reg;
    logic            out_id_reg;
    logic [W-1:0]    rsp_result_reg;
    logic            rsp_cout_reg;
    logic            last_grant_reg;
    logic [CNTW-1:0] cnt_reg [2];

    logic [1:0] valid;
    logic [1:0] rsp_ready;
    logic [1:0] rsp_valid;
    logic [1:0] grant;
    logic       drain;
    logic       can_issue;
    logic       accept;
    logic       winner;

    assign valid     = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    assign drain     = out_valid_reg & rsp_ready[out_id_reg];
    assign can_issue = ~out_valid_reg | drain;

    // On a tie the requester that did not win last time is served.
    // Grants are suppressed during reset so no requester sees a lost handshake.
    assign grant[0] = ~rst & can_issue & valid[0] & (~valid[1] | last_grant_reg);
    assign grant[1] = ~rst & can_issue & valid[1] & (~valid[0] | ~last_grant_reg);
    assign accept   = |grant;
    assign winner   = grant[1];

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        alu_opcode = 4'b0000;
        alu_a      = '0;
        alu_b      = '0;
        if (grant[0]) begin
            alu_opcode = req0_opcode;
            alu_a      = req0_a;
            alu_b      = req0_b;
        end else if (grant[1]) begin
            alu_opcode = req1_opcode;
            alu_a      = req1_a;
            alu_b      = req1_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_id_reg     <= 1'b0;
            rsp_result_reg <= '0;
            rsp_cout_reg   <= 1'b0;
            last_grant_reg <= 1'b1;
        end else if (accept) begin
            out_valid_reg  <= 1'b1;
            out_id_reg     <= winner;
            rsp_result_reg <= alu_result;
            rsp_cout_reg   <= alu_cout;
            last_grant_reg <= winner;
        end else if (drain) begin
            out_valid_reg  <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg[gi] <= '0;
            end else if (grant[gi]) begin
                cnt_reg[gi] <= cnt_reg[gi] + CNTW'(1);
            end
        end
        assign rsp_valid[gi] = out_valid_reg & (out_id_reg == 1'(gi));
    end

    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp_result = rsp_result_reg;
    assign rsp_cout   = rsp_cout_reg;
    assign cnt0       = cnt_reg[0];
    assign cnt1       = cnt_reg[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a small ALU model answers the DUT's operand drive.
module tb_alu_arbiter;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst;
    logic req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0] req0_opcode, req1_opcode, alu_opcode;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_result;
    logic alu_cout, rsp_cout;
    logic rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [15:0] cnt0, cnt1;

    // Second instance with 2-bit counters, fed the same stimulus, for wrap checks
    logic w_req0_ready, w_req1_ready, w_alu_cout_unused;
    logic [3:0] w_alu_opcode;
    logic [W-1:0] w_alu_a, w_alu_b, w_rsp_result;
    logic w_rsp0_valid, w_rsp1_valid, w_rsp_cout;
    logic [1:0] w_cnt0, w_cnt1;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SLT = 4'b1011;
    localparam logic [3:0] OP_SLL = 4'b1101;
    localparam logic [3:0] OP_SRA = 4'b1111;

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        alu_cout   = 1'b0;
        case (alu_opcode)
            OP_ADD: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SLT: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 64'd1 : 64'd0;
            OP_SLL: alu_result = alu_a << alu_b[5:0];
            OP_SRA: alu_result = $signed(alu_a) >>> alu_b[5:0];
            default: alu_result = '0;
        endcase
    end

    alu_arbiter #(.W(W), .CNTW(16)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    alu_arbiter #(.W(W), .CNTW(2)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_opcode(w_alu_opcode), .alu_a(w_alu_a), .alu_b(w_alu_b),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp0_valid(w_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(w_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(w_rsp_result), .rsp_cout(w_rsp_cout),
        .cnt0(w_cnt0), .cnt1(w_cnt1)
    );
    assign w_alu_cout_unused = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_opcode = 0; req1_opcode = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        do_reset();
        settle();

        // Reset state
        chk("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
        chk("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
        chk("rst_rsp_result", rsp_result, 64'd0);
        chk("rst_rsp_cout", 64'(rsp_cout), 64'd0);
        chk("rst_cnt0", 64'(cnt0), 64'd0);
        chk("rst_cnt1", 64'(cnt1), 64'd0);
        chk("rst_alu_opcode", 64'(alu_opcode), 64'd0);

        // req0 alone: SLL 1 by 63
        req0_valid = 1; req0_opcode = OP_SLL; req0_a = 64'd1; req0_b = 64'd63;
        settle();
        chk("sll_req0_ready", 64'(req0_ready), 64'd1);
        chk("sll_req1_ready", 64'(req1_ready), 64'd0);
        chk("sll_alu_opcode", 64'(alu_opcode), 64'(OP_SLL));
        chk("sll_alu_a", alu_a, 64'd1);
        chk("sll_alu_b", alu_b, 64'd63);
        tick();
        req0_valid = 0;
        settle();
        chk("sll_rsp0_valid", 64'(rsp0_valid), 64'd1);
        chk("sll_rsp1_valid", 64'(rsp1_valid), 64'd0);
        chk("sll_rsp_result", rsp_result, 64'h8000_0000_0000_0000);
        chk("sll_cnt0", 64'(cnt0), 64'd1);

        // req1 alone: ADD with carry out
        req1_valid = 1; req1_opcode = OP_ADD; req1_a = '1; req1_b = 64'd1;
        settle();
        chk("add_req1_ready", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 0;
        settle();
        chk("add_rsp1_valid", 64'(rsp1_valid), 64'd1);
        chk("add_rsp0_valid", 64'(rsp0_valid), 64'd0);
        chk("add_rsp_result", rsp_result, 64'd0);
        chk("add_rsp_cout", 64'(rsp_cout), 64'd1);
        chk("add_cnt1", 64'(cnt1), 64'd1);

        // Both valid every cycle: grants alternate starting with req0
        do_reset();
        req0_valid = 1; req0_opcode = OP_SLT; req0_a = '1; req0_b = 64'd1;
        req1_valid = 1; req1_opcode = OP_SRA; req1_a = 64'h8000_0000_0000_0000; req1_b = 64'd4;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("rr_req0_ready_%0d", i), 64'(req0_ready), 64'((i % 2) == 0));
            chk($sformatf("rr_req1_ready_%0d", i), 64'(req1_ready), 64'((i % 2) == 1));
            if (i > 0) begin
                chk($sformatf("rr_rsp0_valid_%0d", i), 64'(rsp0_valid), 64'((i % 2) == 1));
                chk($sformatf("rr_rsp_result_%0d", i), rsp_result,
                    ((i % 2) == 1) ? 64'd1 : 64'hF800_0000_0000_0000);
            end
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        settle();
        chk("rr_last_rsp1_valid", 64'(rsp1_valid), 64'd1);
        chk("rr_last_rsp_result", rsp_result, 64'hF800_0000_0000_0000);
        chk("rr_cnt0", 64'(cnt0), 64'd4);
        chk("rr_cnt1", 64'(cnt1), 64'd4);
        tick();

        // Backpressure: req1 response held while req0 waits
        rsp1_ready = 0;
        req1_valid = 1;
        settle();
        chk("bp_req1_ready", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 0; req0_valid = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("bp_req0_ready_%0d", i), 64'(req0_ready), 64'd0);
            chk($sformatf("bp_rsp1_valid_%0d", i), 64'(rsp1_valid), 64'd1);
            chk($sformatf("bp_rsp_result_%0d", i), rsp_result, 64'hF800_0000_0000_0000);
            tick();
        end
        rsp1_ready = 1;
        settle();
        chk("bp_pass_req0_ready", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 0;
        settle();
        chk("bp_rsp0_valid", 64'(rsp0_valid), 64'd1);
        chk("bp_rsp1_valid", 64'(rsp1_valid), 64'd0);
        chk("bp_rsp_result", rsp_result, 64'd1);
        tick();

        // Idle: ALU driven to zero, slot empty; last grant (req0) remembered
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("idle_alu_opcode_%0d", i), 64'(alu_opcode), 64'd0);
            chk($sformatf("idle_alu_a_%0d", i), alu_a, 64'd0);
            chk($sformatf("idle_alu_b_%0d", i), alu_b, 64'd0);
            chk($sformatf("idle_rsp_valid_%0d", i), 64'({rsp1_valid, rsp0_valid}), 64'd0);
            tick();
        end
        req0_valid = 1; req1_valid = 1;
        settle();
        chk("idle_tie_req1_ready", 64'(req1_ready), 64'd1);
        chk("idle_tie_req0_ready", 64'(req0_ready), 64'd0);
        tick();
        req1_valid = 0;
        tick();
        // Slot now holds a req0 response; hold it and raise req1, then reset
        req0_valid = 0; req1_valid = 1; rsp0_ready = 0;
        settle();
        chk("mid_rsp0_valid", 64'(rsp0_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp0_ready = 1;
        settle();
        chk("mid_rsp0_valid_after", 64'(rsp0_valid), 64'd0);
        chk("mid_rsp1_valid_after", 64'(rsp1_valid), 64'd0);
        chk("mid_cnt0", 64'(cnt0), 64'd0);
        chk("mid_cnt1", 64'(cnt1), 64'd0);
        req0_valid = 1;
        settle();
        chk("mid_tie_req0_ready", 64'(req0_ready), 64'd1);
        chk("mid_tie_req1_ready", 64'(req1_ready), 64'd0);
        tick();
        req0_valid = 0; req1_valid = 0;
        tick();

        // Counter wrap on the 2-bit instance
        do_reset();
        req0_valid = 1; req0_opcode = OP_SLL; req0_a = 64'd3; req0_b = 64'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            chk($sformatf("wrap_cnt0_%0d", i), 64'(w_cnt0), 64'((i + 1) % 4));
        end
        chk("wrap_rsp_result", w_rsp_result, 64'd12);
        req0_valid = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 64-bit combinational ALU between two requesters, req0 and req1.
- Each requester uses a valid/ready request channel and its own valid/ready response channel.
- Arbitration is round-robin. The block drives the ALU operand inputs directly and captures the ALU output into a one-entry response register tagged with the owning requester.
- Sits between the issue logic (two pipes or units) and the alu instance; one-cycle latency, full throughput.

Parameters:
- W, 64, operand/result width; must match the ALU datapath.
- CNTW, 16, width of the per-requester issue counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_opcode  in  4  ALU opcode from requester 0.
- req0_a  in  W  operand A from requester 0.
- req0_b  in  W  operand B from requester 0.
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b  same as req0 ports, for requester 1.
- alu_opcode  out  4  to ALU opcode input.
- alu_a  out  W  to ALU operand A.
- alu_b  out  W  to ALU operand B.
- alu_result  in  W  from ALU result.
- alu_cout  in  1  from ALU carry out.
- rsp0_valid  out  1  response for requester 0 is held.
- rsp0_ready  in  1  requester 0 consumes the response.
- rsp1_valid  out  1  response for requester 1 is held.
- rsp1_ready  in  1  requester 1 consumes the response.
- rsp_result  out  W  registered result; shared by both response channels.
- rsp_cout  out  1  registered carry out.
- cnt0  out  CNTW  number of operations accepted from requester 0.
- cnt1  out  CNTW  number of operations accepted from requester 1.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_id=0, rsp_result=0, rsp_cout=0.
  - last_grant=1, so req0 wins the first tie.
  - cnt0=cnt1=0.
  - Reset overrides any transfer in the same cycle; an in-flight response is discarded.
- Response slot:
  - rsp0_valid = out_valid & (out_id==0); rsp1_valid = out_valid & (out_id==1).
  - drain = out_valid & ready of the owning requester.
- Issue:
  - can_issue = !out_valid | drain. Pass-through: a drain and a new capture in the same cycle are legal.
- Grant (combinational, only when can_issue):
  - Only one requester valid: that requester wins.
  - Both valid: the requester that is not last_grant wins.
  - Neither valid: no grant.
- Ready: reqN_ready = grantN. Ready may depend on valid; requesters must hold valid and payload stable until ready.
- ALU drive:
  - alu_opcode/alu_a/alu_b = the granted requester's fields.
  - With no grant: all zero (opcode 4'b0000, operands 0).
- Capture on an accepted transfer:
  - Next edge: rsp_result<=alu_result, rsp_cout<=alu_cout, out_id<=winner, out_valid<=1.
  - last_grant<=winner; cnt of the winner increments.
- Drain without issue: out_valid<=0; rsp_result and rsp_cout hold their last value.
- No accepted transfer: last_grant unchanged.
- Latency: accepted at edge N, response visible from edge N+1.
- Throughput: 1 op/cycle when the consumer is always ready.
- Backpressure: while the slot is full and the owner is not ready, both reqN_ready=0 and all slot contents hold stable.
- Counters wrap modulo 2^CNTW; no saturation.
- rsp_result is meaningful only while the corresponding rspN_valid is high.
- Opcodes are passed unmodified; no opcode decoding inside this block.

Test Plan:
- Reset, then req0 alone with SLL (4'b1101), A=1, B=63 -> req0_ready=1 that cycle; next cycle rsp0_valid=1, rsp_result=0x8000000000000000, rsp1_valid=0, cnt0=1.
- Both valid every cycle, both rsp_ready=1, req0 SLT (4'b1011) A=-1 B=1, req1 SRA (4'b1111) A=0x8000000000000000 B=4:
  - Grants alternate 0,1,0,1.
  - Responses alternate rsp_result=1 / 0xF800000000000000.
  - After 8 cycles cnt0=4, cnt1=4.
- Backpressure: req1 accepted, rsp1_ready=0 for 3 cycles while req0 stays valid:
  - req0_ready=0 throughout; rsp_result stable.
  - On the cycle rsp1_ready=1, req0_ready=1 (pass-through).
  - Next cycle rsp0_valid=1.
- Idle: no valid for 5 cycles -> alu_opcode=0, alu_a=0, alu_b=0, out_valid=0, last_grant unchanged; the next simultaneous request goes to the non-last requester.
- Reset mid-operation: rst asserted while rsp0_valid=1 and req1_valid=1 -> next cycle out_valid=0, cnt0=cnt1=0, no response delivered; after release req0 wins a tie.
- Counter wrap with CNTW=2: 5 req0 ops -> cnt0 sequence 1,2,3,0,1.
